// File: rtl/servo_pwm_bank.sv
// Eight-channel servo PWM generator: angle commands are converted to pulse widths by a
// serial shift-add multiply, double-buffered, and applied only at 20 ms frame boundaries.
module servo_pwm_bank #(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter int unsigned MIN_CYCLES    = 50000,
  parameter int unsigned STEP_CYCLES   = 278,
  parameter int unsigned MAX_ANGLE     = 180
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pwm_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_channel,
  input  logic [7:0] cmd_angle,
  output logic       cmd_done,
  output logic [7:0] servo_pwm,
  output logic       frame_start
);

  localparam int unsigned CW  = 20;
  localparam int unsigned NCH = 8;
  localparam logic [CW-1:0] CENTRE = CW'(MIN_CYCLES + 90 * STEP_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;

  state_t          state;
  logic [2:0]      ch;
  logic [7:0]      ang;
  logic [2:0]      k;
  logic [CW-1:0]   acc;
  logic [CW-1:0]   step_sh;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   shadow [NCH];
  logic [CW-1:0]   active [NCH];

  // cnt is the frame position the outputs will show after the next edge, so the
  // first cycle after reset release is already position 0 (frame_start).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      servo_pwm   <= '0;
    end else begin
      frame_start <= (cnt == '0);
      for (int i = 0; i < NCH; i++) begin
        servo_pwm[i] <= pwm_en && (cnt < active[i]);
      end
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Shadow takes each finished command; active reloads on the wrap, forwarding a same-cycle write.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= CENTRE;
        active[i] <= CENTRE;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (state == WRITE && ch == 3'(i)) begin
          shadow[i] <= acc;
        end
        if (cnt == LAST) begin
          active[i] <= (state == WRITE && ch == 3'(i)) ? acc : shadow[i];
        end
      end
    end
  end

  // Command FSM: one angle bit per CALC cycle, LSB first, adding the matching shifted step.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ch        <= '0;
      ang       <= '0;
      k         <= '0;
      acc       <= '0;
      step_sh   <= '0;
      cmd_ready <= 1'b1;
      cmd_done  <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ch        <= cmd_channel;
            ang       <= (cmd_angle > 8'(MAX_ANGLE)) ? 8'(MAX_ANGLE) : cmd_angle;
            acc       <= CW'(MIN_CYCLES);
            step_sh   <= CW'(STEP_CYCLES);
            k         <= '0;
            cmd_ready <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          if (ang[0]) begin
            acc <= acc + step_sh;
          end
          ang     <= ang >> 1;
          step_sh <= step_sh << 1;
          k       <= k + 3'd1;
          if (k == 3'd7) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          cmd_done  <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank with shortened frames; a frame-position/width model is checked
// against the DUT every cycle, plus directed pulse-width and latency checks.
module tb_servo_pwm_bank;

  localparam int P    = 3000;
  localparam int MINC = 100;
  localparam int STEP = 15;
  localparam int MAXA = 180;
  localparam int CEN  = MINC + 90 * STEP;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       pwm_en = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_channel = '0;
  logic [7:0] cmd_angle = '0;
  logic       cmd_ready, cmd_done, frame_start;
  logic [7:0] servo_pwm;

  servo_pwm_bank #(
    .PERIOD_CYCLES(P), .MIN_CYCLES(MINC), .STEP_CYCLES(STEP), .MAX_ANGLE(MAXA)
  ) dut (
    .clock(clock), .resetn(resetn), .pwm_en(pwm_en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_channel(cmd_channel), .cmd_angle(cmd_angle),
    .cmd_done(cmd_done), .servo_pwm(servo_pwm), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: position within the frame, widths latched per frame, command pipeline.
  int         m_pos;
  int         m_shadow [8];
  int         m_active [8];
  bit         m_busy;
  int         m_left, m_ch, m_w;
  logic       m_ready, m_done, m_fs;
  logic [7:0] m_pwm;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_pos = -1; m_busy = 0; m_left = 0; m_ch = 0; m_w = 0;
      m_ready = 1'b1; m_done = 1'b0; m_fs = 1'b0; m_pwm = '0;
      for (int i = 0; i < 8; i++) begin
        m_shadow[i] = CEN;
        m_active[i] = CEN;
      end
    end else begin
      m_pos = (m_pos < 0 || m_pos == P - 1) ? 0 : m_pos + 1;
      if (m_pos == 0) begin
        for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
      end
      m_fs = (m_pos == 0);
      for (int i = 0; i < 8; i++) m_pwm[i] = pwm_en && (m_pos < m_active[i]);
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_shadow[m_ch] = m_w;
          m_done = 1'b1;
          m_busy = 0;
        end
      end else if (cmd_valid) begin
        m_busy = 1;
        m_left = 9;
        m_ch   = int'(cmd_channel);
        m_w    = MINC + ((int'(cmd_angle) > MAXA) ? MAXA : int'(cmd_angle)) * STEP;
      end
      m_ready = !m_busy;
    end
  end

  always @(negedge clock) begin
    check("cycle_outputs", {21'd0, cmd_ready, cmd_done, frame_start, servo_pwm},
          {21'd0, m_ready, m_done, m_fs, m_pwm});
  end

  // Frame monitor: position from frame_start and measured high time per channel per frame.
  int pos = -100000;
  int frames = 0;
  int period = 0;
  int last_fs_cyc = 0;
  int hi [8];
  int last_w [8];

  always @(negedge clock) begin
    if (!resetn) begin
      pos = -100000;
      for (int i = 0; i < 8; i++) hi[i] = 0;
    end else if (frame_start) begin
      for (int i = 0; i < 8; i++) begin
        last_w[i] = hi[i];
        hi[i] = int'(servo_pwm[i]);
      end
      period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
      pos = 0;
      frames++;
    end else begin
      pos++;
      for (int i = 0; i < 8; i++) hi[i] += int'(servo_pwm[i]);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int start = frames;
    int b = 0;
    while (frames < start + n && b < n * (P + 100)) begin
      step();
      b++;
    end
    if (frames < start + n) check("frame_timeout", frames, start + n);
  endtask

  task automatic wait_pos(input int p);
    int b = 0;
    while (pos != p && b < P + 100) begin
      step();
      b++;
    end
    if (pos != p) check("pos_timeout", pos, p);
  endtask

  task automatic check_widths(input string name, input int w [8]);
    for (int i = 0; i < 8; i++) check($sformatf("%s_ch%0d", name, i), last_w[i], w[i]);
  endtask

  task automatic send_cmd(input int ch, input int ang, output int lat);
    int b = 0;
    int a;
    cmd_channel = 3'(ch);
    cmd_angle   = 8'(ang);
    cmd_valid   = 1'b1;
    while (!cmd_ready && b < 40) begin
      step();
      b++;
    end
    step();
    a = cyc;
    cmd_valid = 1'b0;
    b = 0;
    while (!cmd_done && b < 40) begin
      step();
      b++;
    end
    lat = cyc - a;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a1, a2, b, dn;
    int w_cen [8] = '{1450, 1450, 1450, 1450, 1450, 1450, 1450, 1450};
    int w_ch2 [8] = '{1450, 1450, 100, 1450, 1450, 1450, 1450, 1450};
    int w_b2b [8] = '{2800, 1450, 100, 1450, 1450, 1450, 1450, 2800};
    int w_ch5 [8] = '{2800, 1450, 100, 1450, 1450, 775, 1450, 2800};
    int w_cut [8] = '{301, 301, 100, 301, 301, 301, 301, 301};

    pwm_en = 1'b1;
    #1 resetn = 1'b0;
    repeat (3) step();
    check("reset_outputs", {21'd0, cmd_ready, cmd_done, frame_start, servo_pwm}, 32'h400);
    resetn = 1'b1;
    step();
    check("first_frame_start", frame_start, 1);

    // Idle frames at centre width.
    wait_frames(2);
    check_widths("centre", w_cen);
    check("frame_period", period, P);

    // Mid-frame command: current frame unchanged, next frame updated.
    wait_pos(500);
    send_cmd(2, 0, lat);
    check("lat_ch2", lat, 9);
    check("model_shadow_ch2", m_shadow[2], 100);
    wait_frames(1);
    check_widths("same_frame", w_cen);
    wait_frames(1);
    check_widths("ch2_angle0", w_ch2);

    // Held cmd_valid: second command accepted 10 cycles after the first; clamp of 250.
    wait_pos(200);
    cmd_channel = 3'd7; cmd_angle = 8'd180; cmd_valid = 1'b1;
    b = 0;
    while (!cmd_ready && b < 40) begin step(); b++; end
    step();
    a1 = cyc;
    cmd_channel = 3'd0; cmd_angle = 8'd250;
    b = 0;
    while (!cmd_ready && b < 40) begin step(); b++; end
    step();
    a2 = cyc;
    cmd_valid = 1'b0;
    check("b2b_gap", a2 - a1, 10);
    b = 0;
    while (!cmd_done && b < 40) begin step(); b++; end
    check("b2b_done_lat", cyc - a2, 9);
    wait_frames(2);
    check_widths("b2b_clamp", w_b2b);

    // Write landing in the last cycle of a frame must reach the next frame.
    wait_pos(P - 11);
    send_cmd(5, 45, lat);
    check("lat_ch5", lat, 9);
    check("ch5_done_pos", pos, P - 1);
    wait_frames(1);
    wait_frames(1);
    check_widths("ch5_boundary", w_ch5);

    // pwm_en cut mid-pulse, restored after all pulses have ended.
    wait_pos(300);
    pwm_en = 1'b0;
    step();
    check("en_off_outputs", servo_pwm, 0);
    wait_pos(2900);
    pwm_en = 1'b1;
    wait_frames(1);
    check_widths("en_cut", w_cut);
    wait_frames(1);
    check_widths("en_resume", w_ch5);

    // Reset during CALC discards the command and restores centre widths.
    wait_pos(1000);
    cmd_channel = 3'd3; cmd_angle = 8'd90; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    resetn = 1'b0;
    step();
    check("mid_reset_outputs", {21'd0, cmd_ready, cmd_done, frame_start, servo_pwm}, 32'h400);
    step();
    resetn = 1'b1;
    step();
    check("reset_frame_start", frame_start, 1);
    check("reset_ready", cmd_ready, 1);
    dn = 0;
    repeat (20) begin
      dn += int'(cmd_done);
      step();
    end
    check("no_done_after_reset", dn, 0);
    wait_frames(2);
    check_widths("after_reset", w_cen);

    // Random commands, gaps and occasional pwm_en toggles against the model.
    a1 = cyc + 5 * P;
    while (cyc < a1) begin
      repeat ($urandom_range(0, 60)) step();
      if ($urandom_range(0, 7) == 0) pwm_en = ~pwm_en;
      send_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), lat);
      check("lat_random", lat, 9);
    end
    pwm_en = 1'b1;
    wait_frames(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
